// File: rtl/flash_sample_streamer.sv
// Prefetches 32-bit flash words into a small sample FIFO, low half first, and feeds
// one attenuated mono sample per codec slot to both DAC channels.
module flash_sample_streamer #(
  parameter int NUM_WORDS  = 1048576,
  parameter int FIFO_DEPTH = 8,
  parameter int VOL_SHIFT  = 6
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  input  logic        write_ready,
  output logic        write_s,
  output logic [15:0] writedata_left,
  output logic [15:0] writedata_right,
  output logic [15:0] underrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [22:0]    LAST_ADDR  = 23'(NUM_WORDS - 1);
  localparam logic [PTR_W:0] ROOM_LIMIT = (PTR_W + 1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_PUSH_HI} fetch_state_e;
  typedef enum logic {C_WAIT_READY, C_WAIT_ACCEPT} codec_state_e;

  fetch_state_e fstate_q, fstate_d;
  codec_state_e cstate_q, cstate_d;

  logic [22:0]    addr_q, addr_d;
  logic [15:0]    hi_q, hi_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [15:0]    underrun_q, underrun_d;

  logic [15:0] fifo_mem [FIFO_DEPTH];

  logic        push;
  logic [15:0] push_data;
  logic        load;
  logic        pop;
  logic [15:0] head_atten;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      fstate_q   <= F_IDLE;
      cstate_q   <= C_WAIT_READY;
      addr_q     <= '0;
      hi_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wdata_q    <= '0;
      underrun_q <= '0;
    end else begin
      fstate_q   <= fstate_d;
      cstate_q   <= cstate_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wdata_q    <= wdata_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage needs no reset: occupancy and pointers alone define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  // Fetch side: one outstanding read; the FIFO always has two free slots when a read starts.
  always_comb begin
    fstate_d  = fstate_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    push      = 1'b0;
    push_data = flash_mem_readdata[15:0];
    case (fstate_q)
      F_IDLE: begin
        if (enable && (count_q <= ROOM_LIMIT)) begin
          fstate_d = F_REQ;
        end
      end
      F_REQ: begin
        if (!flash_mem_waitrequest) begin
          fstate_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (flash_mem_readdatavalid) begin
          push     = 1'b1;
          hi_d     = flash_mem_readdata[31:16];
          fstate_d = F_PUSH_HI;
        end
      end
      F_PUSH_HI: begin
        push      = 1'b1;
        push_data = hi_q;
        addr_d    = (addr_q == LAST_ADDR) ? 23'd0 : addr_q + 23'd1;
        fstate_d  = F_IDLE;
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  assign head_atten = $signed(fifo_mem[rd_ptr_q]) >>> VOL_SHIFT;

  // Codec side: a slot starts only when enabled; an empty FIFO yields a counted silent slot.
  always_comb begin
    cstate_d   = cstate_q;
    wdata_d    = wdata_q;
    underrun_d = underrun_q;
    load       = 1'b0;
    pop        = 1'b0;
    case (cstate_q)
      C_WAIT_READY: begin
        if (enable && write_ready) begin
          load     = 1'b1;
          cstate_d = C_WAIT_ACCEPT;
          if (count_q != '0) begin
            pop     = 1'b1;
            wdata_d = head_atten;
          end else begin
            wdata_d = 16'h0000;
            if (underrun_q != 16'hFFFF) begin
              underrun_d = underrun_q + 16'd1;
            end
          end
        end
      end
      C_WAIT_ACCEPT: begin
        if (!write_ready) begin
          cstate_d = C_WAIT_READY;
        end
      end
      default: cstate_d = C_WAIT_READY;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign flash_mem_read    = (fstate_q == F_REQ);
  assign flash_mem_address = addr_q;
  assign write_s           = (cstate_q == C_WAIT_ACCEPT);
  assign writedata_left    = wdata_q;
  assign writedata_right   = wdata_q;
  assign underrun_count    = underrun_q;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench: behavioural Avalon flash slave with stall/hold controls, codec handshakes
// driven from one linear sequence, hand-computed sample values with a shift of 6.
module tb_flash_sample_streamer;

  logic        CLOCK_50;
  logic        reset;
  logic        enable;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic        write_ready;
  logic        write_s;
  logic [15:0] writedata_left;
  logic [15:0] writedata_right;
  logic [15:0] underrun_count;

  flash_sample_streamer #(
    .NUM_WORDS (4),
    .FIFO_DEPTH(8),
    .VOL_SHIFT (6)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .enable                 (enable),
    .flash_mem_read         (flash_mem_read),
    .flash_mem_address      (flash_mem_address),
    .flash_mem_waitrequest  (flash_mem_waitrequest),
    .flash_mem_readdata     (flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .write_ready            (write_ready),
    .write_s                (write_s),
    .writedata_left         (writedata_left),
    .writedata_right        (writedata_right),
    .underrun_count         (underrun_count)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4];
  logic [22:0] addrLog [$];
  int   acceptCount = 0;
  int   validCount  = 0;
  int   stallNext   = 0;
  int   stallLeft   = 0;
  int   latLeft     = 0;
  bit   pending     = 0;
  bit   holdData    = 0;
  logic [1:0] pendAddr;

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Flash slave: decides at each falling edge what the next rising edge will sample.
  initial begin
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = 32'h0;
    pendAddr                = 2'd0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        pending                 = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        stallNext               = 0;
        stallLeft               = 0;
      end else begin
        if (flash_mem_readdatavalid) begin
          validCount++;
          flash_mem_readdatavalid = 1'b0;
        end
        if (pending && !holdData) begin
          if (latLeft > 1) begin
            latLeft--;
          end else begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = mem[pendAddr];
            pending                 = 1'b0;
          end
        end
        if (flash_mem_read) begin
          if (stallLeft > 0) begin
            flash_mem_waitrequest = 1'b1;
            stallLeft--;
          end else begin
            flash_mem_waitrequest = 1'b0;
            addrLog.push_back(flash_mem_address);
            acceptCount++;
            pending   = 1'b1;
            latLeft   = 1;
            pendAddr  = flash_mem_address[1:0];
            stallNext = 0;
          end
        end else begin
          flash_mem_waitrequest = 1'b0;
          stallLeft = stallNext;
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic wr);
    enable      = en;
    write_ready = wr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic codecHandshake(input string tag, output logic [15:0] left, output logic [15:0] right);
    int waited;
    write_ready = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (write_s !== 1'b1 && waited < 10);
    checkOutput({tag, "_rise_latency"}, 32'(waited), 32'd1);
    left  = writedata_left;
    right = writedata_right;
    write_ready = 1'b0;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (write_s !== 1'b0 && waited < 10);
    checkOutput({tag, "_fall_latency"}, 32'(waited), 32'd1);
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] expSamples [12];
    int readCycles;
    int guard;
    int highCycles;
    bit seenRead;
    bit addrStable;

    mem[0] = 32'h8000_0400;
    mem[1] = 32'hFFFF_0C80;
    mem[2] = 32'hFF80_7FFF;
    mem[3] = 32'hFFBF_0040;
    expSamples = '{16'h0010, 16'hFE00, 16'h0032, 16'hFFFF, 16'h01FF, 16'hFFFE,
                   16'h0001, 16'hFFFE, 16'h0010, 16'hFE00, 16'h0032, 16'hFFFF};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #1;
    checkOutput("rst_read",     32'(flash_mem_read),    32'd0);
    checkOutput("rst_address",  32'(flash_mem_address), 32'd0);
    checkOutput("rst_write_s",  32'(write_s),           32'd0);
    checkOutput("rst_left",     32'(writedata_left),    32'd0);
    checkOutput("rst_right",    32'(writedata_right),   32'd0);
    checkOutput("rst_underrun", 32'(underrun_count),    32'd0);
    repeat (3) @(posedge CLOCK_50);
    #2;
    reset = 1'b0;

    repeat (5) tick();
    checkOutput("paused_no_read", 32'(flash_mem_read), 32'd0);

    // Underrun: data withheld, every slot is silent and counted.
    holdData = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      codecHandshake($sformatf("under%0d", i), l, r);
      checkOutput($sformatf("under%0d_left", i),  32'(l), 32'h0);
      checkOutput($sformatf("under%0d_right", i), 32'(r), 32'h0);
    end
    checkOutput("underrun_count_5", 32'(underrun_count), 32'd5);

    applyStimulus(1'b0, 1'b1);
    highCycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (write_s) highCycles++;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("paused_no_slot",   32'(highCycles),     32'd0);
    checkOutput("paused_underrun",  32'(underrun_count), 32'd5);

    // Pause lets the outstanding read finish; no new request follows.
    tick();
    holdData = 1'b0;
    repeat (10) tick();
    checkOutput("pause_valid_count",  32'(validCount),        32'd1);
    checkOutput("pause_accept_count", 32'(acceptCount),       32'd1);
    checkOutput("pause_address",      32'(flash_mem_address), 32'd1);
    checkOutput("pause_read_low",     32'(flash_mem_read),    32'd0);

    // Reset while a stalled request is on the bus.
    stallNext = 20;
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (flash_mem_read !== 1'b1 && guard < 10);
    checkOutput("midreq_read",    32'(flash_mem_read),    32'd1);
    checkOutput("midreq_address", 32'(flash_mem_address), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_read",     32'(flash_mem_read),    32'd0);
    checkOutput("midrst_address",  32'(flash_mem_address), 32'd0);
    checkOutput("midrst_write_s",  32'(write_s),           32'd0);
    checkOutput("midrst_left",     32'(writedata_left),    32'd0);
    checkOutput("midrst_right",    32'(writedata_right),   32'd0);
    checkOutput("midrst_underrun", 32'(underrun_count),    32'd0);
    addrLog.delete();
    acceptCount = 0;
    validCount  = 0;
    repeat (3) @(posedge CLOCK_50);
    #2;
    reset     = 1'b0;
    stallNext = 3;

    // First request after reset: three wait states hold read/address for four cycles.
    readCycles = 0;
    addrStable = 1'b1;
    seenRead   = 1'b0;
    guard      = 0;
    while (guard < 30) begin
      tick();
      guard++;
      if (flash_mem_read) begin
        seenRead = 1'b1;
        readCycles++;
        if (flash_mem_address != 23'd0) addrStable = 1'b0;
      end else if (seenRead) begin
        break;
      end
    end
    checkOutput("stall_read_cycles", 32'(readCycles),  32'd4);
    checkOutput("stall_addr_stable", 32'(addrStable),  32'd1);
    checkOutput("stall_one_accept",  32'(acceptCount), 32'd1);
    tick();
    tick();
    checkOutput("stall_one_valid",   32'(validCount),  32'd1);

    // Codec stalled: prefetch stops with the FIFO full, address wrapped.
    repeat (200) tick();
    checkOutput("fill_accepts",   32'(acceptCount),       32'd4);
    checkOutput("fill_read_low",  32'(flash_mem_read),    32'd0);
    checkOutput("fill_addr_wrap", 32'(flash_mem_address), 32'd0);
    checkOutput("fill_log_size",  32'(addrLog.size()),    32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fill_log%0d", i), 32'(addrLog[i]), 32'(i));
    end

    // Drain in order while the fetcher wraps through the flash again.
    for (int i = 0; i < 12; i++) begin
      codecHandshake($sformatf("drain%0d", i), l, r);
      checkOutput($sformatf("drain%0d_left", i),  32'(l), 32'(expSamples[i]));
      checkOutput($sformatf("drain%0d_right", i), 32'(r), 32'(expSamples[i]));
    end
    checkOutput("drain_log_ge6",   32'(addrLog.size() >= 6), 32'd1);
    checkOutput("drain_log4",      32'(addrLog[4]),          32'd0);
    checkOutput("drain_log5",      32'(addrLog[5]),          32'd1);
    checkOutput("drain_underrun0", 32'(underrun_count),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
